trigger_capture: RTL and testbench
==================================

# trigger_capture

Acquisition stage that sits directly upstream of the oscilloscope display renderer. It watches the incoming 12-bit ADC sample stream for a level/slope trigger, or for an auto-trigger timeout, and captures 256 decimated samples into a capture buffer. It then copies the completed frame into the `data_display[0:255]` register array during vertical blanking, so the renderer never sees a half-updated frame.

## Interface
- `DEPTH`, 256 — samples per frame; the `data_display` index range is 0..DEPTH-1.
- `WIDTH`, 12 — sample width in bits.
- `AUTO_TIMEOUT`, 100000 — valid samples seen in ARMED without a trigger before a capture is forced (must be ≥ 2).

- `clk` — in, 1 — system/pixel clock; the only clock.
- `rst` — in, 1 — asynchronous, active-low reset.
- `sample_data` — in, WIDTH — ADC sample.
- `sample_valid` — in, 1 — `sample_data` is valid this cycle.
- `trigger_level` — in, WIDTH — unsigned trigger threshold, used live.
- `trigger_slope` — in, 1 — 0 = rising, 1 = falling.
- `decim` — in, 4 — store 1 of every `decim`+1 valid samples during CAPTURE.
- `hold` — in, 1 — freeze: block publication of new frames.
- `vblnk` — in, 1 — vertical blanking from the timing chain.
- `data_display` — out, WIDTH × [0:DEPTH-1] — published frame, registered.
- `frame_valid` — out, 1 — one-cycle pulse, the cycle after a publish.
- `armed` — out, 1 — high while in ARMED.
- `auto_trig` — out, 1 — the published frame came from the timeout, not a real trigger.

## Operation
- FSM states: ARMED, CAPTURE, DONE. Reset state is ARMED.
- **ARMED**
  - Keep `prev` (last valid sample) and `prev_ok` (`prev` holds data since entering ARMED). `prev_ok` clears on entry to ARMED.
  - Rising trigger: `prev_ok` && `prev` < `trigger_level` && `sample_data` ≥ `trigger_level`.
  - Falling trigger: `prev_ok` && `prev` > `trigger_level` && `sample_data` ≤ `trigger_level`.
  - Timeout counter counts valid samples in ARMED and clears on entry. When a valid sample arrives with the counter at AUTO_TIMEOUT-1, that sample is the trigger and `auto_pending` is set.
  - Real trigger and timeout on the same sample: treat as a real trigger, `auto_pending` = 0.
  - On trigger: `buf[0]` <= triggering sample, write index <= 1, decimation counter <= 0, go to CAPTURE.
- **CAPTURE**
  - Decimation counter counts valid samples. The sample that reaches count `decim` is stored at `buf[index]`, then the counter returns to 0 and the index increments. So the stored-sample spacing is `decim`+1 valid samples.
  - `decim` = 0 stores every valid sample. Trigger inputs are ignored in CAPTURE.
  - After `buf[DEPTH-1]` is written, go to DONE.
- **DONE**
  - Incoming samples are dropped.
  - Rising edge of `vblnk` (`vblnk` && !`vblnk_d`) with `hold` = 0: `data_display` <= `buf` (all entries in one cycle), `auto_trig` <= `auto_pending`, go to ARMED.
  - `hold` = 1: stay in DONE. Publication happens on the first `vblnk` rising edge after `hold` falls.
- `hold` has no effect in ARMED or CAPTURE.
- Index and decimation counter are sized so that they do not wrap inside a frame. The index never exceeds DEPTH-1.

## Timing
- Reset (asynchronous assert, synchronous deassert supplied externally):
  - Outputs: `data_display` all 0, `frame_valid` 0, `auto_trig` 0, `armed` 1.
  - Internal: `vblnk_d` 0, counters 0, `prev_ok` 0.
- Reset mid-capture discards the partial frame. `data_display` returns to 0.
- Trigger latency: qualifying sample at edge t → state CAPTURE and `buf[0]` written at edge t. `armed` falls in the cycle after edge t.
- With `sample_valid` held high and `decim` = 0, the frame completes 255 cycles after the trigger edge (DEPTH-1 further samples).
- Publish:
  - `vblnk` rise sampled at edge p → `data_display` updated at edge p.
  - `frame_valid` high for exactly the cycle after edge p.
  - `armed` high from the cycle after edge p.
- A `vblnk` rise during ARMED or CAPTURE is ignored; it is not remembered.
- `sample_valid` gaps stall capture with no loss or duplication.

## Test plan
- **Rising trigger.** Ramp 0,1,2,… with `sample_valid` = 1, `trigger_level` = 100, `decim` = 0, then `vblnk` pulse → `data_display[0]` = 100, `[255]` = 355, `frame_valid` one cycle, `auto_trig` = 0.
- **Falling trigger.** Falling ramp from 500, `trigger_slope` = 1, level 300 → `data_display[0]` = 300, `[1]` = 299. A level already below `trigger_level` at arm does not trigger on the first sample.
- **Decimation.** Ramp, `decim` = 3, level 10 → `data_display[k]` = 10+4k, `[255]` = 1030.
- **Auto-trigger.** Constant input 50, level 1000, `AUTO_TIMEOUT` = 16 → capture starts at the 16th valid sample, all entries 50, `auto_trig` = 1. A simultaneous real crossing on the 16th sample gives `auto_trig` = 0.
- **Hold and blanking.** Frame done while `hold` = 1 across 3 `vblnk` pulses → `data_display` unchanged, no `frame_valid`. Drop `hold` → publish on the next `vblnk` rise only. A `vblnk` rise mid-capture publishes nothing.
- **Reset.** Assert `rst` low mid-capture (index 120) → outputs immediately at reset values. After release, a fresh trigger produces a full, correct frame.

Source files
------------

// File: rtl/trigger_capture_if.sv
// ADC sample stream between the converter front end and the trigger/capture stage.
interface trigger_capture_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] sample_data;
  logic             sample_valid;

  modport master (output sample_data, output sample_valid);
  modport slave  (input  sample_data, input  sample_valid);
endinterface

// File: rtl/trigger_capture.sv
// Level/slope triggered acquisition: captures DEPTH decimated samples and
// publishes the frame to data_display on a vertical-blanking rising edge.
//   state   | meaning
//   ARMED   | watching for a level crossing or the auto-trigger timeout
//   CAPTURE | storing every (decim+1)-th valid sample into cap_buf
//   DONE    | frame complete, waiting for a vblnk rise with hold low
module trigger_capture #(
  parameter int DEPTH        = 256,
  parameter int WIDTH        = 12,
  parameter int AUTO_TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  trigger_capture_if.slave smp,
  input  logic [WIDTH-1:0] trigger_level,
  input  logic             trigger_slope,
  input  logic [3:0]       decim,
  input  logic             hold,
  input  logic             vblnk,
  output logic [WIDTH-1:0] data_display [0:DEPTH-1],
  output logic             frame_valid,
  output logic             armed,
  output logic             auto_trig
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(AUTO_TIMEOUT);

  typedef enum logic [1:0] {ARMED, CAPTURE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] cap_buf [0:DEPTH-1];
  logic [WIDTH-1:0] prev;
  logic             prev_ok;
  logic [TW-1:0]    to_cnt;
  logic [IW-1:0]    wr_idx;
  logic [3:0]       dec_cnt;
  logic             auto_pending;
  logic             vblnk_d;

  logic             sample_valid;
  logic [WIDTH-1:0] sample_data;
  logic             rise_hit;
  logic             fall_hit;
  logic             real_trig;
  logic             to_hit;
  logic             arm_fire;
  logic             cap_store;
  logic             publish;
  logic             buf_we;
  logic [IW-1:0]    buf_idx;

  assign sample_valid = smp.sample_valid;
  assign sample_data  = smp.sample_data;

  assign rise_hit  = prev_ok && (prev < trigger_level) && (sample_data >= trigger_level);
  assign fall_hit  = prev_ok && (prev > trigger_level) && (sample_data <= trigger_level);
  assign real_trig = trigger_slope ? fall_hit : rise_hit;
  assign to_hit    = (to_cnt == TW'(AUTO_TIMEOUT - 1));

  assign arm_fire  = (state == ARMED) && sample_valid && (real_trig || to_hit);
  // >= rather than == keeps the counter from running away if decim drops mid-frame
  assign cap_store = (state == CAPTURE) && sample_valid && (dec_cnt >= decim);
  assign publish   = (state == DONE) && vblnk && !vblnk_d && !hold;

  assign buf_we  = arm_fire || cap_store;
  assign buf_idx = arm_fire ? '0 : wr_idx;

  // Capture buffer is plain storage; only complete frames ever leave it.
  always_ff @(posedge clk) begin
    if (buf_we) cap_buf[buf_idx] <= sample_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARMED;
      prev         <= '0;
      prev_ok      <= 1'b0;
      to_cnt       <= '0;
      wr_idx       <= '0;
      dec_cnt      <= '0;
      auto_pending <= 1'b0;
      vblnk_d      <= 1'b0;
      frame_valid  <= 1'b0;
      armed        <= 1'b1;
      auto_trig    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) data_display[i] <= '0;
    end else begin
      vblnk_d     <= vblnk;
      frame_valid <= 1'b0;
      case (state)
        ARMED: begin
          if (sample_valid) begin
            prev    <= sample_data;
            prev_ok <= 1'b1;
            to_cnt  <= to_cnt + TW'(1);
            if (real_trig || to_hit) begin
              auto_pending <= !real_trig;
              wr_idx       <= IW'(1);
              dec_cnt      <= '0;
              to_cnt       <= '0;
              armed        <= 1'b0;
              state        <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            if (cap_store) begin
              dec_cnt <= '0;
              if (wr_idx == IW'(DEPTH - 1)) begin
                wr_idx <= '0;
                state  <= DONE;
              end else begin
                wr_idx <= wr_idx + IW'(1);
              end
            end else begin
              dec_cnt <= dec_cnt + 4'd1;
            end
          end
        end
        DONE: begin
          if (publish) begin
            data_display <= cap_buf;
            auto_trig    <= auto_pending;
            frame_valid  <= 1'b1;
            armed        <= 1'b1;
            prev_ok      <= 1'b0;
            to_cnt       <= '0;
            state        <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: trigger modes, decimation, auto-trigger,
// hold/blanking behaviour and mid-capture reset, with hand-computed frames.
module tb_trigger_capture;
  localparam int DEPTH = 256;
  localparam int WIDTH = 12;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] trigger_level;
  logic             trigger_slope;
  logic [3:0]       decim;
  logic             hold;
  logic             vblnk;
  logic [WIDTH-1:0] data_display [0:DEPTH-1];
  logic             frame_valid;
  logic             armed;
  logic             auto_trig;

  int checks   = 0;
  int failures = 0;
  int fv_count = 0;
  int exp_fv   = 0;

  trigger_capture_if #(.WIDTH(WIDTH)) smp_if ();

  trigger_capture #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AUTO_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .smp(smp_if.slave),
    .trigger_level(trigger_level), .trigger_slope(trigger_slope),
    .decim(decim), .hold(hold), .vblnk(vblnk),
    .data_display(data_display), .frame_valid(frame_valid),
    .armed(armed), .auto_trig(auto_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid) fv_count <= fv_count + 1;

  task automatic chk(input string tag, input int obs, input int want);
    checks++;
    if (obs != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic put(input int v, input bit vld);
    @(negedge clk);
    smp_if.sample_data  = WIDTH'(v);
    smp_if.sample_valid = vld;
  endtask

  task automatic idle(input int n);
    repeat (n) put(0, 1'b0);
  endtask

  // Feeds n valid samples start, start+step, ...; gap inserts invalid cycles.
  task automatic feed_ramp(input int start, input int step, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && (i % 7 == 3)) put(4095, 1'b0);
      put(start + i * step, 1'b1);
    end
  endtask

  task automatic pulse_vblnk();
    @(negedge clk);
    smp_if.sample_valid = 1'b0;
    vblnk = 1'b1;
    @(negedge clk);
    vblnk = 1'b0;
  endtask

  task automatic do_publish(input string tag);
    pulse_vblnk();
    chk({tag, "_fv_hi"}, int'(frame_valid), 1);
    idle(1);
    chk({tag, "_fv_lo"}, int'(frame_valid), 0);
    exp_fv++;
    chk({tag, "_fv_cnt"}, fv_count, exp_fv);
    chk({tag, "_armed"}, int'(armed), 1);
  endtask

  initial begin
    rst = 1'b0;
    smp_if.sample_data = '0;
    smp_if.sample_valid = 1'b0;
    trigger_level = 12'd100;
    trigger_slope = 1'b0;
    decim = 4'd0;
    hold = 1'b0;
    vblnk = 1'b0;
    idle(3);
    chk("rst_armed", int'(armed), 1);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_auto", int'(auto_trig), 0);
    chk("rst_d0", int'(data_display[0]), 0);
    chk("rst_d255", int'(data_display[255]), 0);
    @(negedge clk);
    rst = 1'b1;

    // Rising trigger at 100 on a ramp starting at 90
    feed_ramp(90, 1, 11, 1'b0);
    chk("rise_armed_pre", int'(armed), 1);
    feed_ramp(101, 1, 1, 1'b0);
    chk("rise_armed_post", int'(armed), 0);
    feed_ramp(102, 1, 260, 1'b0);
    idle(2);
    chk("rise_unpub_fv", fv_count, 0);
    chk("rise_unpub_d0", int'(data_display[0]), 0);
    do_publish("rise");
    chk("rise_d0", int'(data_display[0]), 100);
    chk("rise_d128", int'(data_display[128]), 228);
    chk("rise_d255", int'(data_display[255]), 355);
    chk("rise_auto", int'(auto_trig), 0);

    // Falling trigger at 300; first sample already below the level must not fire
    trigger_slope = 1'b1;
    trigger_level = 12'd300;
    feed_ramp(250, 0, 1, 1'b0);
    feed_ramp(310, -1, 1, 1'b0);
    chk("fall_first_below", int'(armed), 1);
    feed_ramp(309, -1, 10, 1'b0);
    feed_ramp(299, -1, 260, 1'b0);
    idle(2);
    do_publish("fall");
    chk("fall_d0", int'(data_display[0]), 300);
    chk("fall_d1", int'(data_display[1]), 299);
    chk("fall_d255", int'(data_display[255]), 45);

    // Decimation by 4 with valid gaps and a vblnk rise during capture
    trigger_slope = 1'b0;
    trigger_level = 12'd10;
    decim = 4'd3;
    feed_ramp(5, 1, 200, 1'b1);
    vblnk = 1'b1;
    feed_ramp(205, 1, 3, 1'b0);
    vblnk = 1'b0;
    feed_ramp(208, 1, 840, 1'b1);
    idle(3);
    chk("dec_midcap_fv", fv_count, exp_fv);
    chk("dec_midcap_d0", int'(data_display[0]), 300);
    do_publish("dec");
    chk("dec_d0", int'(data_display[0]), 10);
    chk("dec_d1", int'(data_display[1]), 14);
    chk("dec_d100", int'(data_display[100]), 410);
    chk("dec_d255", int'(data_display[255]), 1030);

    // Auto trigger on the 16th valid sample of a constant input
    decim = 4'd0;
    trigger_level = 12'd1000;
    feed_ramp(50, 0, 15, 1'b1);
    idle(1);
    chk("auto_armed_15", int'(armed), 1);
    feed_ramp(50, 0, 1, 1'b0);
    idle(1);
    chk("auto_armed_16", int'(armed), 0);
    feed_ramp(50, 0, 260, 1'b0);
    idle(2);
    do_publish("auto");
    chk("auto_flag", int'(auto_trig), 1);
    chk("auto_d0", int'(data_display[0]), 50);
    chk("auto_d255", int'(data_display[255]), 50);

    // Real crossing coinciding with the timeout sample
    trigger_level = 12'd100;
    feed_ramp(50, 0, 15, 1'b0);
    idle(1);
    chk("coin_armed_15", int'(armed), 1);
    feed_ramp(150, 1, 262, 1'b0);
    idle(2);
    do_publish("coin");
    chk("coin_flag", int'(auto_trig), 0);
    chk("coin_d0", int'(data_display[0]), 150);
    chk("coin_d1", int'(data_display[1]), 151);
    chk("coin_d255", int'(data_display[255]), 405);

    // Hold across three blanking pulses, then release while vblnk is high
    hold = 1'b1;
    trigger_level = 12'd20;
    feed_ramp(15, 1, 270, 1'b0);
    idle(2);
    repeat (3) pulse_vblnk();
    idle(2);
    chk("hold_fv", fv_count, exp_fv);
    chk("hold_d0", int'(data_display[0]), 150);
    @(negedge clk);
    vblnk = 1'b1;
    @(negedge clk);
    hold = 1'b0;
    idle(2);
    vblnk = 1'b0;
    idle(2);
    chk("hold_rel_fv", fv_count, exp_fv);
    chk("hold_rel_d0", int'(data_display[0]), 150);
    do_publish("hold");
    chk("hold_d0_pub", int'(data_display[0]), 20);
    chk("hold_d255_pub", int'(data_display[255]), 275);

    // Reset at capture index 120, then a fresh full frame
    trigger_level = 12'd40;
    feed_ramp(35, 1, 125, 1'b0);
    @(negedge clk);
    smp_if.sample_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_armed", int'(armed), 1);
    chk("mrst_fv", int'(frame_valid), 0);
    chk("mrst_d0", int'(data_display[0]), 0);
    chk("mrst_d255", int'(data_display[255]), 0);
    @(negedge clk);
    rst = 1'b1;
    trigger_level = 12'd60;
    feed_ramp(55, 1, 270, 1'b0);
    idle(2);
    do_publish("post_rst");
    chk("post_rst_d0", int'(data_display[0]), 60);
    chk("post_rst_d128", int'(data_display[128]), 188);
    chk("post_rst_d255", int'(data_display[255]), 315);
    chk("post_rst_auto", int'(auto_trig), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
